// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ
// wclk-domain requesters, with full-flag backpressure and burst capping.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                      wclk,
    input  logic                      wrst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATA_SIZE-1:0] req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ack,
    input  logic                      wfull,
    output logic                      winc,
    output logic [DATA_SIZE-1:0]      wdata,
    output logic                      grant_vld,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      burst_trunc
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          r_state;
    logic            r_grant_vld;
    logic [IW-1:0]   r_grant_id;
    logic [IW-1:0]   r_last_id;
    logic [CW-1:0]   r_cnt;
    logic            r_trunc;

    logic [IW-1:0]   w_sel;
    logic [IW-1:0]   w_idx;
    logic            w_req_g;
    logic            w_last_g;
    logic            w_beat;
    logic            w_at_max;

    // Walk from farthest to nearest so the nearest set bit after last_id wins
    always_comb begin
        w_sel = '0;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IW'((int'(r_last_id) + k) % NREQ);
            if (req[w_idx]) w_sel = w_idx;
        end
    end

    assign w_req_g  = req[r_grant_id];
    assign w_last_g = req_last[r_grant_id];
    assign w_beat   = (r_state == BURST) & w_req_g & ~wfull;
    assign w_at_max = (r_cnt == CW'(MAX_BURST - 1));

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state     <= IDLE;
            r_grant_vld <= 1'b0;
            r_grant_id  <= '0;
            r_last_id   <= IW'(NREQ - 1);
            r_cnt       <= '0;
            r_trunc     <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_state     <= BURST;
                        r_grant_vld <= 1'b1;
                        r_grant_id  <= w_sel;
                        r_last_id   <= w_sel;
                        r_cnt       <= '0;
                    end
                end
                BURST: begin
                    if (!w_req_g) begin
                        r_state     <= IDLE;
                        r_grant_vld <= 1'b0;
                    end else if (w_beat) begin
                        if (w_last_g) begin
                            r_state     <= IDLE;
                            r_grant_vld <= 1'b0;
                        end else if (w_at_max) begin
                            r_state     <= IDLE;
                            r_grant_vld <= 1'b0;
                            r_trunc     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_grant_vld <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        req_ack = '0;
        if (w_beat) req_ack[r_grant_id] = 1'b1;
    end

    always_comb begin
        wdata = '0;
        if (r_grant_vld)
            wdata = req_data[int'(r_grant_id)*DATA_SIZE +: DATA_SIZE];
    end

    assign winc        = w_beat;
    assign grant_vld   = r_grant_vld;
    assign grant_id    = r_grant_id;
    assign burst_trunc = r_trunc;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, 8-bit data,
// MAX_BURST=16, modelled FIFO depth 4 for the fill test).
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int MAXB  = 16;
    localparam int DEPTH = 4;

    logic            wclk = 1'b0;
    logic            wrst_n;
    logic [NREQ-1:0] req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] req_last;
    logic [NREQ-1:0] req_ack;
    logic            wfull;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic            grant_vld;
    logic [1:0]      grant_id;
    logic            burst_trunc;

    int n_tests = 0;
    int n_fail  = 0;
    int n_trunc = 0;
    int n_viol  = 0;
    logic [DW-1:0] wq[$];

    fifo_wr_arbiter #(
        .NREQ(NREQ), .DATA_SIZE(DW), .MAX_BURST(MAXB)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
        .req_last(req_last), .req_ack(req_ack), .wfull(wfull),
        .winc(winc), .wdata(wdata), .grant_vld(grant_vld),
        .grant_id(grant_id), .burst_trunc(burst_trunc)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) begin
        if (winc) begin
            wq.push_back(wdata);
            if (wfull) n_viol++;
        end
        if (burst_trunc) n_trunc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; req_last = '0; req_data = '0; wfull = 1'b0;
        wrst_n = 1'b0;
        tick();
        tick();
        wrst_n = 1'b1;
    endtask

    initial begin
        int k;
        int cyc;
        int cnt;
        int bad;
        int exp_id;
        logic beat_now;

        // Reset state
        do_reset();
        #1;
        chk("rst_vld",   32'(grant_vld),   32'd0);
        chk("rst_id",    32'(grant_id),    32'd0);
        chk("rst_trunc", 32'(burst_trunc), 32'd0);
        chk("rst_winc",  32'(winc),        32'd0);
        chk("rst_ack",   32'(req_ack),     32'd0);
        chk("rst_wdata", 32'(wdata),       32'd0);

        // Single requester, 3 beats
        wq.delete();
        req = 4'b0100; req_data[23:16] = 8'hA1;
        #1;
        chk("t1_nogrant_yet", 32'(grant_vld), 32'd0);
        tick();
        chk("t1_vld", 32'(grant_vld), 32'd1);
        chk("t1_id",  32'(grant_id),  32'd2);
        for (int b = 0; b < 3; b++) begin
            req_data[23:16] = 8'(8'hA1 + b);
            req_last[2] = (b == 2);
            #1;
            chk("t1_winc", 32'(winc),    32'd1);
            chk("t1_ack",  32'(req_ack), 32'b0100);
            chk("t1_data", 32'(wdata),   32'(8'hA1 + b));
            tick();
        end
        req = '0; req_last = '0;
        #1;
        chk("t1_end_vld",   32'(grant_vld),   32'd0);
        chk("t1_end_trunc", 32'(burst_trunc), 32'd0);
        chk("t1_nwr", 32'(wq.size()), 32'd3);
        if (wq.size() == 3) begin
            chk("t1_q0", 32'(wq[0]), 32'hA1);
            chk("t1_q1", 32'(wq[1]), 32'hA2);
            chk("t1_q2", 32'(wq[2]), 32'hA3);
        end

        // Round-robin from reset: 0,1,2,3,0 with one idle cycle between
        do_reset();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'(8'h10 + i);
        req = 4'b1111; req_last = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_id = g % NREQ;
            tick();
            chk("rr_vld",  32'(grant_vld), 32'd1);
            chk("rr_id",   32'(grant_id),  32'(exp_id));
            chk("rr_winc", 32'(winc),      32'd1);
            chk("rr_data", 32'(wdata),     32'(8'h10 + exp_id));
            tick();
            chk("rr_idle", 32'(grant_vld), 32'd0);
        end
        req = '0; req_last = '0;
        tick();

        // Full backpressure in the middle of a 4-beat burst
        wq.delete();
        req = 4'b0010; req_data[15:8] = 8'h30;
        tick();
        chk("bp_id", 32'(grant_id), 32'd1);
        tick();
        req_data[15:8] = 8'h31;
        tick();
        wfull = 1'b1; req_data[15:8] = 8'h32;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("bp_winc", 32'(winc),      32'd0);
            chk("bp_ack",  32'(req_ack),   32'd0);
            chk("bp_hold", 32'(grant_vld), 32'd1);
            tick();
        end
        wfull = 1'b0;
        #1;
        chk("bp_resume", 32'(winc), 32'd1);
        tick();
        req_data[15:8] = 8'h33; req_last[1] = 1'b1;
        tick();
        req = '0; req_last = '0;
        #1;
        chk("bp_end", 32'(grant_vld), 32'd0);
        chk("bp_nwr", 32'(wq.size()), 32'd4);
        if (wq.size() == 4) chk("bp_q3", 32'(wq[3]), 32'h33);

        // Truncation at MAX_BURST, then regrant of the same requester
        wq.delete(); n_trunc = 0;
        req = 4'b0010;
        k = 0; cyc = 0;
        while (k < 20 && cyc < 80) begin
            req_data[15:8] = 8'(8'h40 + k);
            req_last[1] = (k == 19);
            #1;
            beat_now = req_ack[1];
            if (beat_now) k++;
            tick();
            cyc++;
            if (beat_now && k == 16) begin
                chk("tr_pulse", 32'(burst_trunc), 32'd1);
                chk("tr_idle",  32'(grant_vld),   32'd0);
            end
            if (beat_now && k == 17)
                chk("tr_regrant", 32'(grant_id), 32'd1);
        end
        chk("tr_beats", 32'(k), 32'd20);
        req = '0; req_last = '0;
        tick();
        chk("tr_npulse", 32'(n_trunc), 32'd1);
        chk("tr_nwr", 32'(wq.size()), 32'd20);
        bad = 0;
        foreach (wq[i]) if (wq[i] !== 8'(8'h40 + i)) bad++;
        chk("tr_order", 32'(bad), 32'd0);

        // Abandon after 2 beats
        wq.delete();
        req = 4'b0001; req_data[7:0] = 8'h50;
        tick();
        chk("ab_id", 32'(grant_id), 32'd0);
        tick();
        req_data[7:0] = 8'h51;
        tick();
        req = '0;
        #1;
        chk("ab_nobeat", 32'(winc), 32'd0);
        tick();
        chk("ab_idle", 32'(grant_vld), 32'd0);
        chk("ab_nwr", 32'(wq.size()), 32'd2);

        // Asynchronous reset in the middle of a burst
        req = 4'b1000; req_data[31:24] = 8'h60;
        tick();
        chk("rs_id",   32'(grant_id), 32'd3);
        chk("rs_winc", 32'(winc),     32'd1);
        req = 4'b1001;
        wrst_n = 1'b0;
        #1;
        chk("rs_vld",  32'(grant_vld), 32'd0);
        chk("rs_winc0", 32'(winc),     32'd0);
        chk("rs_ack",  32'(req_ack),   32'd0);
        tick();
        wrst_n = 1'b1;
        tick();
        chk("rs_prio", 32'(grant_id), 32'd0);
        req = '0;
        tick();
        tick();

        // Stream DEPTH+4 beats into a modelled empty FIFO with no reads
        do_reset();
        wq.delete();
        n_viol = 0;
        req = 4'b0100;
        k = 0; cnt = 0;
        for (int c = 0; c < 40; c++) begin
            wfull = (cnt >= DEPTH);
            req_data[23:16] = 8'(8'h70 + k);
            req_last[2] = (k == DEPTH + 3);
            #1;
            if (req_ack[2]) begin
                k++;
                cnt++;
            end
            tick();
        end
        chk("ff_acc",  32'(cnt),       32'(DEPTH));
        chk("ff_nwr",  32'(wq.size()), 32'(DEPTH));
        chk("ff_viol", 32'(n_viol),    32'd0);
        chk("ff_hold", 32'(grant_vld), 32'd1);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
